// File: rtl/endec_stream_host_pkg.sv
// Shared constants and types for the endec stream host.
// Holds the encoder/decoder core dimensions, the request packet field offsets,
// the response split point and the host FSM state type.
package endec_stream_host_pkg;

  // Core dimensions
  localparam int unsigned MAX_CONSTRAINT_LENGTH = 9;
  localparam int unsigned MAX_CODE_RATE         = 3;
  localparam int unsigned MAX_STATE_REG_NUM     = 8;
  localparam int unsigned GEN_POLY_W            = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;

  // Stream geometry
  localparam int unsigned AXIS_W          = 64;
  localparam int unsigned ENDEC_REQ_BEATS = 10;
  localparam int unsigned ENDEC_RSP_BEATS = 11;
  localparam int unsigned REQ_W           = AXIS_W * ENDEC_REQ_BEATS;
  localparam int unsigned RSP_W           = AXIS_W * ENDEC_RSP_BEATS;
  localparam int unsigned BEAT_CNT_W      = 4;

  // Request packet field offsets
  localparam int unsigned POLY_LSB    = 0;
  localparam int unsigned RATE_BIT    = 27;
  localparam int unsigned STATE_LSB   = 28;
  localparam int unsigned ENC_LSB     = 64;
  localparam int unsigned DEC_LSB     = 256;
  localparam int unsigned ENC_FRAME_W = 192;
  localparam int unsigned DEC_FRAME_W = 384;

  // Response split
  localparam int unsigned ENC_RSP_W = 576;
  localparam int unsigned DEC_RSP_W = RSP_W - ENC_RSP_W;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StRecv,
    StDone
  } host_state_e;

endpackage

// File: rtl/endec_rsp_deser.sv
// Response deserializer for the endec stream host.
// Collects up to 11 response beats into a 704-bit register, checks tlast
// framing and enforces the inter-beat timeout.
// Ports:
//   sys_clk, rst_n          clock, async active-low reset
//   start                   arm collection (pulse on the last request handshake)
//   s_axis_*                response stream slave
//   complete                collection finished this cycle (beat, early tlast or timeout)
//   err                     the finishing event is a framing error or timeout
//   rsp_next                response register contents including this cycle's beat
module endec_rsp_deser
  import endec_stream_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AXIS_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              complete,
  output logic              err,
  output logic [RSP_W-1:0]  rsp_next
);

  logic                  active_q;
  logic [BEAT_CNT_W-1:0] rx_cnt_q;
  logic [31:0]           idle_cnt_q;
  logic [RSP_W-1:0]      rsp_q;

  logic beat;
  logic last_slot;
  logic timeout;

  always_comb begin
    beat      = active_q & s_axis_tvalid;
    last_slot = (rx_cnt_q == BEAT_CNT_W'(ENDEC_RSP_BEATS - 1));
    // idle_cnt_q counts cycles elapsed since the last beat, that beat's cycle being 1
    timeout   = active_q && !s_axis_tvalid && (TIMEOUT_CYCLES != 0) &&
                ((idle_cnt_q + 32'd1) >= 32'(TIMEOUT_CYCLES));
    complete  = timeout | (beat & (s_axis_tlast | last_slot));
    // tlast must coincide with beat 10 exactly; either mismatch is a framing error
    err       = timeout | (beat & (s_axis_tlast ^ last_slot));
    rsp_next  = rsp_q;
    if (beat) begin
      rsp_next[AXIS_W*rx_cnt_q +: AXIS_W] = s_axis_tdata;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      rx_cnt_q   <= '0;
      idle_cnt_q <= '0;
      rsp_q      <= '0;
    end else begin
      rsp_q <= rsp_next;
      if (start) begin
        active_q   <= 1'b1;
        rx_cnt_q   <= '0;
        idle_cnt_q <= 32'd1;
      end else if (active_q) begin
        if (complete) begin
          active_q <= 1'b0;
        end
        if (beat) begin
          rx_cnt_q   <= rx_cnt_q + BEAT_CNT_W'(1);
          idle_cnt_q <= 32'd1;
        end else begin
          idle_cnt_q <= idle_cnt_q + 32'd1;
        end
      end
    end
  end

  assign s_axis_tready = active_q;

endmodule

// File: rtl/endec_stream_host.sv
// Host-side AXI-Stream endpoint for the convolutional encoder/decoder core.
// Captures one job, serializes it as a 10-beat request packet, then collects
// the 11-beat response and presents encoder/decoder results with a done pulse.
// Ports:
//   sys_clk, rst_n                 clock, async active-low reset
//   i_start / o_busy               job request (sampled in IDLE) / not-idle flag
//   i_code_rate, i_gen_poly_flat,
//   i_prv_encoder_state,
//   i_encoder_data_frame,
//   i_decoder_data_frame           job fields, captured on i_start
//   m_axis_*                       request stream master
//   s_axis_*                       response stream slave
//   o_encoder_data, o_decoder_data results, updated when o_done pulses
//   o_done, o_err                  completion pulse / framing error or timeout
module endec_stream_host
  import endec_stream_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  output logic                         o_busy,
  input  logic                         i_code_rate,
  input  logic [GEN_POLY_W-1:0]        i_gen_poly_flat,
  input  logic [MAX_STATE_REG_NUM-1:0] i_prv_encoder_state,
  input  logic [ENC_FRAME_W-1:0]       i_encoder_data_frame,
  input  logic [DEC_FRAME_W-1:0]       i_decoder_data_frame,
  output logic [AXIS_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  input  logic [AXIS_W-1:0]            s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [ENC_RSP_W-1:0]         o_encoder_data,
  output logic [DEC_RSP_W-1:0]         o_decoder_data,
  output logic                         o_done,
  output logic                         o_err
);

  host_state_e           state_q, state_d;
  logic [REQ_W-1:0]      req_q;
  logic [REQ_W-1:0]      req_word;
  logic [BEAT_CNT_W-1:0] tx_cnt_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [ENC_RSP_W-1:0]  enc_q;
  logic [DEC_RSP_W-1:0]  dec_q;

  logic                  capture;
  logic                  tx_hs;
  logic                  send_last;
  logic                  rsp_complete;
  logic                  rsp_err;
  logic [RSP_W-1:0]      rsp_next;

  always_comb begin
    req_word = '0;
    req_word[POLY_LSB +: GEN_POLY_W]         = i_gen_poly_flat;
    req_word[RATE_BIT]                       = i_code_rate;
    req_word[STATE_LSB +: MAX_STATE_REG_NUM] = i_prv_encoder_state;
    req_word[ENC_LSB +: ENC_FRAME_W]         = i_encoder_data_frame;
    req_word[DEC_LSB +: DEC_FRAME_W]         = i_decoder_data_frame;
  end

  always_comb begin
    capture   = (state_q == StIdle) && i_start;
    tx_hs     = tvalid_q && m_axis_tready;
    send_last = tx_hs && (tx_cnt_q == BEAT_CNT_W'(ENDEC_REQ_BEATS - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_start) state_d = StSend;
      StSend: if (send_last) state_d = StRecv;
      StRecv: if (rsp_complete) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      req_q    <= '0;
      tx_cnt_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      enc_q    <= '0;
      dec_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      if (capture) begin
        req_q    <= req_word;
        tx_cnt_q <= '0;
        tvalid_q <= 1'b1;
        tlast_q  <= 1'b0;
      end else if (tx_hs) begin
        // The request register shifts so the current beat is always in the low word
        req_q    <= req_q >> AXIS_W;
        tx_cnt_q <= tx_cnt_q + BEAT_CNT_W'(1);
        tlast_q  <= (tx_cnt_q == BEAT_CNT_W'(ENDEC_REQ_BEATS - 2));
        if (send_last) begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      end
      if ((state_q == StRecv) && rsp_complete) begin
        enc_q <= rsp_next[ENC_RSP_W-1:0];
        dec_q <= rsp_next[RSP_W-1:ENC_RSP_W];
        err_q <= rsp_err;
      end
    end
  end

  endec_rsp_deser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_deser (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .start        (send_last),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .complete     (rsp_complete),
    .err          (rsp_err),
    .rsp_next     (rsp_next)
  );

  assign m_axis_tdata   = req_q[AXIS_W-1:0];
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_encoder_data = enc_q;
  assign o_decoder_data = dec_q;

endmodule

// File: tb/tb_endec_stream_host.sv
// Directed bench for endec_stream_host with a request-beat scoreboard and a
// bench-side model of the response register.
module tb_endec_stream_host;

  localparam int unsigned TO = 8;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic         o_busy;
  logic         i_code_rate;
  logic [26:0]  i_gen_poly_flat;
  logic [7:0]   i_prv_encoder_state;
  logic [191:0] i_encoder_data_frame;
  logic [383:0] i_decoder_data_frame;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [63:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [575:0] o_encoder_data;
  logic [127:0] o_decoder_data;
  logic         o_done;
  logic         o_err;

  int vectors = 0;
  int miscompares = 0;

  logic [64:0]  exp_q[$];       // {tlast, tdata} per expected request beat
  logic [703:0] rsp_model = '0;

  always #5 sys_clk = ~sys_clk;

  endec_stream_host #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk             (sys_clk),
    .rst_n               (rst_n),
    .i_start             (i_start),
    .o_busy              (o_busy),
    .i_code_rate         (i_code_rate),
    .i_gen_poly_flat     (i_gen_poly_flat),
    .i_prv_encoder_state (i_prv_encoder_state),
    .i_encoder_data_frame(i_encoder_data_frame),
    .i_decoder_data_frame(i_decoder_data_frame),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tready       (m_axis_tready),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .o_encoder_data      (o_encoder_data),
    .o_decoder_data      (o_decoder_data),
    .o_done              (o_done),
    .o_err               (o_err)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [26:0] poly, input logic rate, input logic [7:0] st,
                        input logic [191:0] enc, input logic [383:0] dec);
    logic [639:0] req;
    req = {dec, enc, 28'h0, st, rate, poly};
    i_gen_poly_flat      = poly;
    i_code_rate          = rate;
    i_prv_encoder_state  = st;
    i_encoder_data_frame = enc;
    i_decoder_data_frame = dec;
    for (int k = 0; k < 10; k++) exp_q.push_back({(k == 9), req[64*k +: 64]});
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    // Inputs are free to change once captured
    i_encoder_data_frame = '1;
    i_decoder_data_frame = '1;
    i_gen_poly_flat      = '1;
  endtask

  task automatic run_send(input int stall_beat, input int n_beats);
    int hs;
    int stall;
    logic [64:0] e;
    hs = 0;
    stall = 0;
    for (int cyc = 0; cyc < 100 && hs < n_beats; cyc++) begin
      if (m_axis_tvalid) begin
        if (hs == stall_beat && stall < 3) begin
          m_axis_tready = 1'b0;
          stall++;
          chk("stall_tdata", m_axis_tdata, exp_q[0][63:0]);
          chk("stall_tlast", 64'(m_axis_tlast), 64'(exp_q[0][64]));
        end else begin
          m_axis_tready = 1'b1;
          e = exp_q.pop_front();
          chk($sformatf("req_beat%0d_tdata", hs), m_axis_tdata, e[63:0]);
          chk($sformatf("req_beat%0d_tlast", hs), 64'(m_axis_tlast), 64'(e[64]));
          hs++;
        end
      end
      tick();
    end
    m_axis_tready = 1'b1;
    chk("req_handshakes", 64'(hs), 64'(n_beats));
  endtask

  task automatic run_rsp(input int n, input int tlast_idx, input logic [63:0] base);
    for (int k = 0; k < n; k++) begin
      chk("rsp_tready", 64'(s_axis_tready), 64'd1);
      s_axis_tdata  = base + 64'(k);
      s_axis_tlast  = (k == tlast_idx);
      s_axis_tvalid = 1'b1;
      rsp_model[64*k +: 64] = base + 64'(k);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_result(input logic exp_err);
    logic [703:0] got;
    got = {o_decoder_data, o_encoder_data};
    chk("done_pulse", 64'(o_done), 64'd1);
    chk("err", 64'(o_err), 64'(exp_err));
    chk("rsp_tready_low", 64'(s_axis_tready), 64'd0);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("result_word%0d", k), got[64*k +: 64], rsp_model[64*k +: 64]);
    end
    tick();
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("busy_low", 64'(o_busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 64'd0);
    chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_err"}, 64'(o_err), 64'd0);
    chk({tag, "_enc_or"}, 64'(|o_encoder_data), 64'd0);
    chk({tag, "_dec_or"}, 64'(|o_decoder_data), 64'd0);
  endtask

  initial begin
    logic [191:0] enc_a;
    logic [383:0] dec_a;
    int n;

    rst_n = 1'b0;
    i_start = 1'b0;
    i_code_rate = 1'b0;
    i_gen_poly_flat = '0;
    i_prv_encoder_state = '0;
    i_encoder_data_frame = '0;
    i_decoder_data_frame = '0;
    m_axis_tready = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    for (int i = 0; i < 24; i++) enc_a[8*i +: 8] = 8'(i);
    for (int i = 0; i < 48; i++) dec_a[8*i +: 8] = 8'(24 + i);

    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Job A: capture/serialize with backpressure on beat 4, normal response
    launch(27'h5A5A5A5, 1'b1, 8'hC3, enc_a, dec_a);
    chk("busy_after_start", 64'(o_busy), 64'd1);
    chk("tvalid_after_start", 64'(m_axis_tvalid), 64'd1);
    chk("beat0_const", m_axis_tdata, 64'h0000000C_3DA5A5A5);
    run_send(4, 10);
    chk("m_tvalid_after_send", 64'(m_axis_tvalid), 64'd0);
    chk("s_tready_after_send", 64'(s_axis_tready), 64'd1);
    run_rsp(11, 10, 64'd0);
    chk("enc_low_word", o_encoder_data[63:0], 64'd0);
    chk("dec_high_word", o_decoder_data[127:64], 64'd10);
    check_result(1'b0);

    // Job B: early tlast on response beat 6, upper words keep job A values
    launch(27'h1234567, 1'b0, 8'h5E, ~enc_a, ~dec_a);
    run_send(-1, 10);
    run_rsp(7, 6, 64'hB000_0000_0000_0000);
    check_result(1'b1);

    // Job C: timeout after response beat 2
    launch(27'h0F0F0F0, 1'b1, 8'h11, enc_a ^ 192'h55, dec_a);
    run_send(-1, 10);
    run_rsp(3, -1, 64'hC000_0000_0000_0000);
    n = 0;
    while (!o_done && n < 50) begin
      tick();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(TO - 1));
    check_result(1'b1);

    // Job D: 11th beat without tlast is a framing error
    launch(27'h7FFFFFF, 1'b0, 8'hFF, enc_a, ~dec_a);
    run_send(-1, 10);
    run_rsp(11, -1, 64'hD000_0000_0000_0000);
    check_result(1'b1);

    // Job E: clean job after the error cases clears o_err
    launch(27'h0000001, 1'b1, 8'h01, ~enc_a, dec_a);
    run_send(-1, 10);
    run_rsp(11, 10, 64'hE000_0000_0000_0000);
    check_result(1'b0);

    // Job F: reset during request beat 5
    launch(27'h2AAAAAA, 1'b0, 8'hA5, enc_a, dec_a);
    run_send(-1, 5);
    chk("beat5_pending", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    exp_q.delete();
    rsp_model = '0;
    tick();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    tick();

    // Job G: full clean job after reset
    launch(27'h5A5A5A5, 1'b1, 8'hC3, enc_a, dec_a);
    run_send(2, 10);
    run_rsp(11, 10, 64'hF000_0000_0000_0000);
    check_result(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/endec_stream_host.md
# endec_stream_host

Host-side AXI-Stream endpoint for the convolutional encoder/decoder core. It takes one job: code rate, generator polynomials, previous encoder state, a 192-bit encoder frame and a 384-bit decoder frame. It serializes the job into the 10-beat, 640-bit request packet the endec stream interface expects. It then collects the 11-beat, 704-bit response and unpacks it into encoder and decoder results. It sits between the processor/DMA-side control logic and the endec stream interface, within the same clock domain.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: maximum idle cycles allowed between response beats. A value of 0 disables the timeout.

Ports:
- sys_clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  job request; sampled only in IDLE.
- o_busy  out  1  high whenever the block is not in IDLE.
- i_code_rate  in  1  code rate select.
- i_gen_poly_flat  in  `MAX_CONSTRAINT_LENGTH*`MAX_CODE_RATE (27)  generator polynomials.
- i_prv_encoder_state  in  `MAX_STATE_REG_NUM (8)  initial encoder state.
- i_encoder_data_frame  in  192  data to encode.
- i_decoder_data_frame  in  384  symbols to decode.
- m_axis_tdata / m_axis_tvalid / m_axis_tlast  out  64/1/1  request stream.
- m_axis_tready  in  1  request stream ready.
- s_axis_tdata / s_axis_tvalid / s_axis_tlast  in  64/1/1  response stream.
- s_axis_tready  out  1  response stream ready.
- o_encoder_data  out  576  encoder result.
- o_decoder_data  out  128  decoder result.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  the completed job had a framing error or a timeout.

## Operation
- States and transitions:
  - IDLE → SEND on i_start.
  - SEND → RECV on the handshake of beat 9.
  - RECV → DONE on the 11th beat, on an early tlast, or on a timeout.
  - DONE → IDLE unconditionally.
- Job capture on i_start in IDLE, into a 640-bit request register:
  - bits [26:0] = gen_poly
  - bit [27] = code_rate
  - bits [35:28] = prv_encoder_state
  - bits [63:36] = 0
  - bits [255:64] = encoder frame
  - bits [639:256] = decoder frame
- i_start is ignored while o_busy=1. Input ports may change freely after the capture cycle.
- SEND:
  - m_axis_tvalid=1.
  - m_axis_tdata = request bits [64k+63:64k] for beat k (k = 0..9).
  - m_axis_tlast=1 only on beat 9.
  - Beat counter advances only on tvalid&tready.
  - tdata and tlast stay stable while stalled.
- RECV:
  - s_axis_tready=1.
  - Beat k is stored into response bits [64k+63:64k].
  - Response layout: bits [575:0] = encoder data (beats 0–8); bits [703:576] = decoder data (beats 9–10).
- Framing rules:
  - tlast on beat k<10: stop collecting and set the error flag. Unreceived bits keep their previous contents.
  - Beat 10 without tlast: the job completes and the error flag is set. Later beats are not accepted until the next job.
- Timeout:
  - The idle counter clears on each accepted response beat and on entry to RECV.
  - When the counter reaches TIMEOUT_CYCLES, the error flag is set and the state moves to DONE.
- DONE:
  - o_encoder_data and o_decoder_data are loaded from the response register.
  - o_err is loaded from the error flag.
  - o_done=1 for exactly one cycle.
  - The result outputs hold until the next DONE. The error flag clears on the next capture.

## Timing
- Reset values: all outputs are 0; state is IDLE; all counters are 0.
- i_start at cycle 0: o_busy and m_axis_tvalid are 1 from cycle 1. With tready held high, beats go out on cycles 1–10.
- s_axis_tready rises the cycle after the beat-9 handshake.
- o_done rises the cycle after the final response beat (or the timeout cycle). o_busy falls one cycle later.
- A new i_start is accepted on the cycle o_busy=0, so back-to-back jobs have a 1-cycle IDLE gap.
- All outputs are registered; no combinational path runs from the s_axis inputs to s_axis_tready.
- Simultaneous i_start and DONE cannot occur, because i_start is sampled only in IDLE.
- Reset mid-job: state, counters and valid/ready signals clear immediately and the job is abandoned. The peer shares rst_n, so dropping tvalid without a handshake is acceptable here.

## Structure
- Shared package (param_def.sv): the existing MAX_CONSTRAINT_LENGTH, MAX_CODE_RATE and MAX_STATE_REG_NUM, plus:
  - new constants ENDEC_REQ_BEATS=10 and ENDEC_RSP_BEATS=11;
  - request field offsets (POLY_LSB=0, RATE_BIT=27, STATE_LSB=28, ENC_LSB=64, DEC_LSB=256);
  - the response split ENC_RSP_W=576.
- One sub-module is natural: endec_rsp_deser. It owns the RECV beat counter, the tlast checks, the timeout counter and the 704-bit response register, and reports complete/err to the top FSM.

## Test plan
- Capture and serialize: gen_poly=27'h5A5A5A5, rate=1, state=8'hC3, and an enc/dec frame with an incrementing byte pattern; tready=1.
  - Beat 0 = 64'h0000000C_3DA5A5A5.
  - Beats 1–9 carry the frame slices; tlast only on beat 9.
- Backpressure: drop m_axis_tready for 3 cycles on beat 4. Beat 4's tdata/tlast stay stable; there are still exactly 10 handshakes.
- Normal response: send 11 beats with payload = beat index, tlast on beat 10.
  - o_encoder_data[63:0]=0 and o_decoder_data[127:64]=10.
  - o_done is a 1-cycle pulse and o_err=0.
- Early tlast on response beat 6: o_done with o_err=1. o_encoder_data[447:0] is updated and the upper bits are unchanged.
- Timeout with TIMEOUT_CYCLES=8: stop the response after beat 2. o_done and o_err=1 arrive 8 cycles after beat 2; the next job then completes with o_err=0.
- Reset: assert rst_n=0 during SEND beat 5. All outputs are 0 asynchronously; after release, i_start runs a clean full job.
